// File: rtl/cpu_fetch.sv
// Instruction fetch/sequencing unit.
// Fetches one instruction at a time, hands it to execute, waits for the
// branch resolution, then computes the next pc. A HALT opcode stops
// fetching until reset.
module cpu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_resolve_valid,
    input  logic        i_branch,
    input  logic        i_branch_zero,
    input  logic        i_branch_nonzero,
    input  logic        i_alu_zero,
    input  logic [63:0] i_br_offset,
    output logic [63:0] o_pc,
    output logic        o_halted
);

    // Start address with the low two bits cleared so pc stays word aligned.
    localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};
    localparam logic [10:0] HALT_OPCODE      = 11'h7FF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_RESOLVE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic        r_halted;

    logic        w_taken;
    logic        w_is_halt;
    logic [63:0] w_step;
    logic [63:0] w_next_pc;

    // Branch decision and next-pc arithmetic (64-bit, wraps modulo 2^64).
    always_comb begin
        w_taken   = i_branch
                  | (i_branch_zero    &  i_alu_zero)
                  | (i_branch_nonzero & ~i_alu_zero);
        w_is_halt = (r_instr[31:21] == HALT_OPCODE);
        w_step    = w_taken ? (i_br_offset << 2) : 64'd4;
        w_next_pc = (r_pc + w_step) & ~64'd3;
    end

    // Sequencer: state, pc, latched instruction and registered handshakes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC_ALIGNED;
            r_instr       <= 32'h0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc       <= RESET_PC_ALIGNED;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_instr       <= i_imem_rdata;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_instr_ready) begin
                        r_instr_valid <= 1'b0;
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state  <= S_RESOLVE;
                        end
                    end
                end
                S_RESOLVE: begin
                    // Branch flags only matter on the resolve_valid cycle.
                    if (i_resolve_valid) begin
                        r_pc       <= w_next_pc;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_halted      <= 1'b1;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    // Request address is the current pc, held while waiting for ack.
    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: sequential run, branch variants, wrap,
// back-pressure and reset abandonment.
module tb_cpu_fetch;

    localparam logic [31:0] ADD  = 32'h8B00_0000;
    localparam logic [31:0] HLT  = 32'hFFE0_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        resolve_valid = 1'b0;
    logic        branch = 1'b0;
    logic        branch_zero = 1'b0;
    logic        branch_nonzero = 1'b0;
    logic        alu_zero = 1'b0;
    logic [63:0] br_offset = 64'h0;
    logic [63:0] pc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    cpu_fetch #(.RESET_PC(64'h0)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_rdata    (imem_rdata),
        .o_instr         (instr),
        .o_instr_valid   (instr_valid),
        .i_instr_ready   (instr_ready),
        .i_resolve_valid (resolve_valid),
        .i_branch        (branch),
        .i_branch_zero   (branch_zero),
        .i_branch_nonzero(branch_nonzero),
        .i_alu_zero      (alu_zero),
        .i_br_offset     (br_offset),
        .o_pc            (pc),
        .o_halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, check its address, return data with ack.
    task automatic do_fetch(input logic [63:0] exp_addr, input logic [31:0] data);
        for (int i = 0; i < 20 && !imem_req; i++) step();
        chk("fetch_req", {63'h0, imem_req}, 64'h1);
        chk("fetch_addr", imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = JUNK;
        chk("fetch_instr", {32'h0, instr}, {32'h0, data});
        chk("fetch_valid", {63'h0, instr_valid}, 64'h1);
        $display("fetch addr=%h data=%h", exp_addr, data);
    endtask

    task automatic do_issue(input logic exp_halt);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("issue_valid_drop", {63'h0, instr_valid}, 64'h0);
        chk("issue_halted", {63'h0, halted}, {63'h0, exp_halt});
        $display("issue instr=%h halted=%0b", instr, halted);
    endtask

    task automatic do_resolve(input logic b, input logic bz, input logic bnz,
                              input logic z, input logic [63:0] off,
                              input logic [63:0] exp_pc);
        branch = b; branch_zero = bz; branch_nonzero = bnz; alu_zero = z;
        br_offset = off;
        resolve_valid = 1'b1;
        step();
        resolve_valid = 1'b0;
        branch = 1'b0; branch_zero = 1'b0; branch_nonzero = 1'b0; alu_zero = 1'b0;
        chk("resolve_pc", pc, exp_pc);
        chk("resolve_req", {63'h0, imem_req}, 64'h1);
        $display("resolve b=%0b bz=%0b bnz=%0b z=%0b off=%h -> pc=%h", b, bz, bnz, z, off, pc);
    endtask

    task automatic run(input logic [63:0] addr, input logic b, input logic bz,
                       input logic bnz, input logic z, input logic [63:0] off,
                       input logic [63:0] exp_pc);
        do_fetch(addr, ADD);
        do_issue(1'b0);
        do_resolve(b, bz, bnz, z, off, exp_pc);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_req", {63'h0, imem_req}, 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_instr", {32'h0, instr}, 64'h0);
        chk("rst_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_halted", {63'h0, halted}, 64'h0);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("idle_no_req", {63'h0, imem_req}, 64'h0);

        // Sequential ADD then HALT
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_req", {63'h0, imem_req}, 64'h1);
        do_fetch(64'h0, ADD);
        do_issue(1'b0);
        do_resolve(1'b0, 1'b0, 1'b0, 1'b0, 64'd7, 64'h4);
        do_fetch(64'h4, HLT);
        do_issue(1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("halt_no_req", {63'h0, imem_req}, 64'h0);
            chk("halt_stays", {63'h0, halted}, 64'h1);
            step();
        end

        // Restart for branch tests
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_halted", {63'h0, halted}, 64'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        run(64'h0,   1, 0, 0, 0, 64'h40, 64'h100);
        run(64'h100, 0, 1, 0, 1, -64'sd2, 64'hF8);        // CBZ taken
        run(64'hF8,  1, 0, 0, 0, 64'd2,  64'h100);
        run(64'h100, 0, 1, 0, 0, -64'sd2, 64'h104);       // CBZ not taken
        run(64'h104, 1, 0, 0, 0, -64'sd57, 64'h20);
        run(64'h20,  1, 0, 0, 0, 64'd5,  64'h34);         // B
        run(64'h34,  0, 0, 1, 0, 64'd1,  64'h38);         // CBNZ taken
        run(64'h38,  0, 0, 1, 1, 64'd7,  64'h3C);         // CBNZ not taken
        run(64'h3C,  1, 0, 0, 0, -64'sd16, 64'hFFFF_FFFF_FFFF_FFFC);
        run(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 64'd9, 64'h0);  // forward wrap
        run(64'h0,   1, 0, 0, 0, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFC); // backward wrap
        run(64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 1, 64'd3, 64'h8); // flags OR

        // Flags ignored without resolve_valid; ack and start ignored in RESOLVE
        do_fetch(64'h8, ADD);
        do_issue(1'b0);
        branch = 1'b1; br_offset = 64'd100;
        imem_ack = 1'b1; imem_rdata = JUNK; start = 1'b1;
        step();
        imem_ack = 1'b0; start = 1'b0;
        step();
        chk("resolve_wait_pc", pc, 64'h8);
        chk("resolve_wait_req", {63'h0, imem_req}, 64'h0);
        chk("resolve_ack_ignored", {32'h0, instr}, {32'h0, ADD});
        branch = 1'b0;
        do_resolve(1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'hC);

        // Back-pressure on memory then on execute
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_req", {63'h0, imem_req}, 64'h1);
            chk("bp_addr", imem_addr, 64'hC);
        end
        do_fetch(64'hC, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", {63'h0, instr_valid}, 64'h1);
            chk("bp_instr", {32'h0, instr}, 64'h1234_5678);
        end
        do_issue(1'b0);
        step();
        chk("bp_single_transfer", {63'h0, instr_valid}, 64'h0);

        // Asynchronous reset in RESOLVE
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {63'h0, imem_req}, 64'h0);
        chk("arst_addr", imem_addr, 64'h0);
        chk("arst_instr", {32'h0, instr}, 64'h0);
        chk("arst_valid", {63'h0, instr_valid}, 64'h0);
        chk("arst_pc", pc, 64'h0);
        step();
        rst_n = 1'b1;
        imem_ack = 1'b1; instr_ready = 1'b1; resolve_valid = 1'b1; imem_rdata = JUNK;
        step(); step();
        imem_ack = 1'b0; instr_ready = 1'b0; resolve_valid = 1'b0;
        chk("post_rst_req", {63'h0, imem_req}, 64'h0);
        chk("post_rst_valid", {63'h0, instr_valid}, 64'h0);
        chk("post_rst_instr", {32'h0, instr}, 64'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        do_fetch(64'h0, ADD);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0, first fetch address after start; bits [1:0] forced to 0 internally.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins execution from RESET_PC.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  64  byte address of requested instruction.
REQ-007 imem_ack  input  1  memory has returned imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 instr  output  32  instruction presented to decode/control (bits [31:21] drive the control decoder opcode input).
REQ-010 instr_valid  output  1  instr is valid.
REQ-011 instr_ready  input  1  execute stage accepts instr.
REQ-012 resolve_valid  input  1  control/ALU results for the issued instruction are valid.
REQ-013 branch  input  1  unconditional branch (B).
REQ-014 branch_zero  input  1  CBZ.
REQ-015 branch_nonzero  input  1  CBNZ.
REQ-016 alu_zero  input  1  ALU zero flag for the issued instruction.
REQ-017 br_offset  input  64  sign-extended branch offset in words.
REQ-018 pc  output  64  address of the current/most recent instruction.
REQ-019 halted  output  1  HALT instruction retired; fetch stopped.

Function
REQ-020 The block SHALL implement states IDLE, FETCH, ISSUE, RESOLVE, HALT.
REQ-021 IDLE: all request/valid outputs 0; start=1 SHALL load pc<=RESET_PC and move to FETCH next cycle.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack=1; on ack, latch imem_rdata into instr and move to ISSUE.
REQ-024 imem_ack outside FETCH SHALL be ignored; instr SHALL not change.
REQ-025 ISSUE: instr_valid=1, instr stable until instr_ready=1; transfer occurs on the cycle both are 1.
REQ-026 On transfer, if instr[31:21]==11'b11111111111 (HALT), go to HALT; otherwise go to RESOLVE.
REQ-027 RESOLVE: wait for resolve_valid; branch/condition inputs SHALL be sampled only on the resolve_valid cycle.
REQ-028 taken = branch | (branch_zero & alu_zero) | (branch_nonzero & ~alu_zero); multiple flags asserted combine by this OR.
REQ-029 On resolve: pc <= taken ? pc + (br_offset<<2) : pc + 4, then FETCH; arithmetic 64-bit modulo 2^64 (wraps silently, both directions).
REQ-030 pc bits [1:0] SHALL always be 0.
REQ-031 HALT: halted=1, imem_req=0, instr_valid=0; exit only via reset.
REQ-032 Minimum instruction period: 1 cycle FETCH (ack same cycle) + 1 ISSUE + 1 RESOLVE = 3 cycles.
REQ-033 Outputs imem_req, instr_valid, halted SHALL be registered state decodes (no combinational path from inputs).

Reset
REQ-034 rst_n=0 SHALL immediately force: state IDLE, pc=RESET_PC, instr=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, halted=0.
REQ-035 Reset asserted mid-FETCH/ISSUE/RESOLVE SHALL abandon the transaction; a pending ack or ready after release is ignored until a new start.
REQ-036 After rst_n deasserts the block SHALL remain in IDLE until start.

Verification
REQ-037 Sequential: RESET_PC=0, start, memory returns ADD (0x8B000000) then HALT (0xFFE00000), resolve with all flags 0 -> imem_addr 0 then 4; halted=1 after second transfer; no third imem_req.
REQ-038 CBZ taken/not-taken: pc=0x100, branch_zero=1, br_offset=-2: alu_zero=1 -> next imem_addr 0xF8; alu_zero=0 -> 0x104.
REQ-039 B and CBNZ: branch=1, br_offset=5 at pc=0x20 -> 0x34; branch_nonzero=1, alu_zero=0, offset=1 at pc=0x34 -> 0x38.
REQ-040 Back-pressure: hold imem_ack=0 for 4 cycles then instr_ready=0 for 3 cycles -> imem_addr, instr stable throughout; exactly one transfer.
REQ-041 Wrap: pc=0xFFFF_FFFF_FFFF_FFFC, not taken -> next pc 0x0.
REQ-042 Reset mid-RESOLVE, then ack/ready/start pulses: outputs at reset values instantly; start in RESOLVE before reset ignored; post-reset start fetches RESET_PC.
